// File: rtl/fhe_op_sequencer.sv
// -----------------------------------------------------------------------------
// fhe_op_sequencer
//
// Purpose:
//   Queues FHE operation commands and walks each one row by row over rows
//   0..DIMENSION. For every row it reads both operand SRAMs, pulses the
//   compute unit, and writes the result SRAM as the opcode requires:
//     ADD     : sum of the operand words written in EXEC, one write per row
//     MULT    : compute-unit result written in a WRITE cycle, one per row
//     ENC/DEC : a single write of the compute-unit result after the last row
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cmd_*                       command push interface (valid/ready)
//   op1_*/op2_*                 operand SRAM read ports (1-cycle read latency)
//   unit_*                      compute-unit strobe, opcode, row and result
//   out_*                       result SRAM write port
//   busy, done, cmd_count       status
//
// States:
//   S_IDLE   | wait for a queued command, pop it into the working registers
//   S_READ   | issue operand reads for the current row
//   S_EXEC   | operand data valid; pulse the compute unit (ADD writes here)
//   S_WRITE  | write compute-unit result (MULT every row, ENC/DEC once)
//   S_FINISH | one-cycle done pulse
// -----------------------------------------------------------------------------
module fhe_op_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int ADDR_WIDTH       = 10,
    parameter int DIM_WIDTH        = 4,
    parameter int CMD_DEPTH        = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_opcode,
    input  logic [ADDR_WIDTH-1:0]         cmd_op1_base,
    input  logic [ADDR_WIDTH-1:0]         cmd_op2_base,
    input  logic [ADDR_WIDTH-1:0]         cmd_out_base,

    output logic                          op1_ren,
    output logic                          op2_ren,
    output logic [ADDR_WIDTH-1:0]         op1_radr,
    output logic [ADDR_WIDTH-1:0]         op2_radr,
    input  logic [CIPHERTEXT_WIDTH-1:0]   op1_rdata,
    input  logic [CIPHERTEXT_WIDTH-1:0]   op2_rdata,

    output logic                          unit_en,
    output logic [1:0]                    unit_opcode,
    output logic [DIM_WIDTH-1:0]          unit_row,
    input  logic [CIPHERTEXT_WIDTH-1:0]   unit_result,

    output logic                          out_wen,
    output logic [ADDR_WIDTH-1:0]         out_wadr,
    output logic [CIPHERTEXT_WIDTH-1:0]   out_wdata,

    output logic                          busy,
    output logic                          done,
    output logic [$clog2(CMD_DEPTH):0]    cmd_count
);

    localparam int PTR_W   = $clog2(CMD_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + 3 * ADDR_WIDTH;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MULT = 2'b11;

    localparam logic [DIM_WIDTH-1:0] LAST_ROW = DIM_WIDTH'(DIMENSION);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_FINISH
    } state_t;

    // ---------------------------------------------------------------- queue
    logic [ENTRY_W-1:0] r_fifo [CMD_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    state_t             r_state;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens a slot early.
    assign w_ready = (r_count < CNT_W'(CMD_DEPTH));
    assign w_push  = cmd_valid && w_ready;
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
    assign w_head  = r_fifo[r_rptr];

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {cmd_opcode, cmd_op1_base, cmd_op2_base, cmd_out_base};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [1:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_op1_base;
    logic [ADDR_WIDTH-1:0] r_op2_base;
    logic [ADDR_WIDTH-1:0] r_out_base;
    logic [DIM_WIDTH-1:0]  r_row;

    logic                  r_op1_ren;
    logic                  r_op2_ren;
    logic [ADDR_WIDTH-1:0] r_op1_radr;
    logic [ADDR_WIDTH-1:0] r_op2_radr;
    logic                  r_unit_en;
    logic [1:0]            r_unit_opcode;
    logic [DIM_WIDTH-1:0]  r_unit_row;
    logic                  r_out_wen;
    logic [ADDR_WIDTH-1:0] r_out_wadr;
    logic                  r_done;

    logic                  w_last_row;
    logic [DIM_WIDTH-1:0]  w_next_row;
    logic                  w_advance;

    assign w_last_row = (r_row == LAST_ROW);
    assign w_next_row = r_row + 1'b1;

    // The row's final action is complete: WRITE always, EXEC for ADD, and
    // EXEC for ENC/DEC on every row except the last (which still owes a WRITE).
    assign w_advance = (r_state == S_WRITE) ||
                       ((r_state == S_EXEC) &&
                        ((r_opcode == OP_ADD) ||
                         (((r_opcode == OP_ENC) || (r_opcode == OP_DEC)) && !w_last_row)));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_op1_base    <= '0;
            r_op2_base    <= '0;
            r_out_base    <= '0;
            r_row         <= '0;
            r_op1_ren     <= 1'b0;
            r_op2_ren     <= 1'b0;
            r_op1_radr    <= '0;
            r_op2_radr    <= '0;
            r_unit_en     <= 1'b0;
            r_unit_opcode <= '0;
            r_unit_row    <= '0;
            r_out_wen     <= 1'b0;
            r_out_wadr    <= '0;
            r_done        <= 1'b0;
        end else begin
            // Strobes and their qualifiers are single-cycle unless re-armed.
            r_op1_ren     <= 1'b0;
            r_op2_ren     <= 1'b0;
            r_op1_radr    <= '0;
            r_op2_radr    <= '0;
            r_unit_en     <= 1'b0;
            r_unit_opcode <= '0;
            r_unit_row    <= '0;
            r_out_wen     <= 1'b0;
            r_out_wadr    <= '0;
            r_done        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_opcode   <= w_head[3*ADDR_WIDTH +: 2];
                        r_op1_base <= w_head[2*ADDR_WIDTH +: ADDR_WIDTH];
                        r_op2_base <= w_head[ADDR_WIDTH +: ADDR_WIDTH];
                        r_out_base <= w_head[0 +: ADDR_WIDTH];
                        r_row      <= '0;
                        r_op1_ren  <= 1'b1;
                        r_op2_ren  <= 1'b1;
                        r_op1_radr <= w_head[2*ADDR_WIDTH +: ADDR_WIDTH];
                        r_op2_radr <= w_head[ADDR_WIDTH +: ADDR_WIDTH];
                        r_state    <= S_READ;
                    end
                end

                S_READ: begin
                    r_unit_en     <= 1'b1;
                    r_unit_row    <= r_row;
                    r_unit_opcode <= r_opcode;
                    if (r_opcode == OP_ADD) begin
                        r_out_wen  <= 1'b1;
                        r_out_wadr <= r_out_base + ADDR_WIDTH'(r_row);
                    end
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    if (r_opcode == OP_MULT) begin
                        r_out_wen  <= 1'b1;
                        r_out_wadr <= r_out_base + ADDR_WIDTH'(r_row);
                        r_state    <= S_WRITE;
                    end else if (r_opcode != OP_ADD && w_last_row) begin
                        r_out_wen  <= 1'b1;
                        r_out_wadr <= r_out_base;
                        r_state    <= S_WRITE;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= r_state;
                end
            endcase

            if (w_advance) begin
                if (w_last_row) begin
                    r_done  <= 1'b1;
                    r_state <= S_FINISH;
                end else begin
                    r_row      <= w_next_row;
                    r_op1_ren  <= 1'b1;
                    r_op2_ren  <= 1'b1;
                    r_op1_radr <= r_op1_base + ADDR_WIDTH'(w_next_row);
                    r_op2_radr <= r_op2_base + ADDR_WIDTH'(w_next_row);
                    r_state    <= S_READ;
                end
            end
        end
    end

    // Write data comes straight from the SRAM / compute-unit inputs in the
    // cycle they are valid, so it cannot be registered ahead of time.
    logic [CIPHERTEXT_WIDTH-1:0] w_out_wdata;

    always_comb begin
        w_out_wdata = '0;
        if (r_state == S_EXEC && r_opcode == OP_ADD) begin
            w_out_wdata = op1_rdata + op2_rdata;
        end else if (r_state == S_WRITE) begin
            w_out_wdata = unit_result;
        end
    end

    assign cmd_ready   = w_ready && !wb_rst_i;
    assign cmd_count   = r_count;
    assign busy        = !((r_state == S_IDLE) && (r_count == '0));
    assign done        = r_done;
    assign op1_ren     = r_op1_ren;
    assign op2_ren     = r_op2_ren;
    assign op1_radr    = r_op1_radr;
    assign op2_radr    = r_op2_radr;
    assign unit_en     = r_unit_en;
    assign unit_opcode = r_unit_opcode;
    assign unit_row    = r_unit_row;
    assign out_wen     = r_out_wen;
    assign out_wadr    = r_out_wadr;
    assign out_wdata   = w_out_wdata;

endmodule

// File: tb/tb_fhe_op_sequencer.sv
module tb_fhe_op_sequencer;
    localparam int CW        = 10;
    localparam int DIMENSION = 10;
    localparam int AW        = 10;
    localparam int DW        = 4;
    localparam int DEPTH     = 4;
    localparam int ROWS      = DIMENSION + 1;
    localparam int AMOD      = 1 << AW;
    localparam int DMOD      = 1 << CW;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MULT = 2'b11;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_opcode;
    logic [AW-1:0]  cmd_op1_base, cmd_op2_base, cmd_out_base;
    logic           op1_ren, op2_ren;
    logic [AW-1:0]  op1_radr, op2_radr;
    logic [CW-1:0]  op1_rdata, op2_rdata;
    logic           unit_en;
    logic [1:0]     unit_opcode;
    logic [DW-1:0]  unit_row;
    logic [CW-1:0]  unit_result;
    logic           out_wen;
    logic [AW-1:0]  out_wadr;
    logic [CW-1:0]  out_wdata;
    logic           busy, done;
    logic [2:0]     cmd_count;

    always #5 wb_clk_i = ~wb_clk_i;

    fhe_op_sequencer #(
        .CIPHERTEXT_WIDTH(CW), .DIMENSION(DIMENSION), .ADDR_WIDTH(AW),
        .DIM_WIDTH(DW), .CMD_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op1_base(cmd_op1_base), .cmd_op2_base(cmd_op2_base), .cmd_out_base(cmd_out_base),
        .op1_ren(op1_ren), .op2_ren(op2_ren), .op1_radr(op1_radr), .op2_radr(op2_radr),
        .op1_rdata(op1_rdata), .op2_rdata(op2_rdata),
        .unit_en(unit_en), .unit_opcode(unit_opcode), .unit_row(unit_row), .unit_result(unit_result),
        .out_wen(out_wen), .out_wadr(out_wadr), .out_wdata(out_wdata),
        .busy(busy), .done(done), .cmd_count(cmd_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge wb_clk_i) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------ environment models
    logic [CW-1:0] mem1 [AMOD];
    logic [CW-1:0] mem2 [AMOD];
    int uk_mul = 0;
    int uk_add = 0;

    // Compute unit result is a simple function of the row it was given.
    function automatic int unit_fn(input int row);
        return (row * uk_mul + uk_add) % DMOD;
    endfunction

    always @(posedge wb_clk_i) begin
        if (op1_ren) op1_rdata <= mem1[op1_radr];
        if (op2_ren) op2_rdata <= mem2[op2_radr];
    end

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)     unit_result <= '0;
        else if (unit_en) unit_result <= CW'(unit_fn(int'(unit_row)));
    end

    // ------------------------------------------------ reference scoreboard
    typedef struct {
        logic [1:0] op;
        int         b1;
        int         b2;
        int         bo;
    } cmd_t;

    cmd_t cmd_q[$];
    int n_ren = 0, n_unit = 0, n_wr = 0, start_c = 0;
    int spur_wen = 0, spur_done = 0, done_total = 0;

    always @(negedge wb_clk_i) begin
        cmd_t c;
        int   exp_a, exp_d, exp_lat, exp_wr;
        logic quiet_ok;
        if (wb_rst_i) begin
            cmd_q.delete();
            n_ren = 0; n_unit = 0; n_wr = 0;
        end else begin
            quiet_ok = (op1_ren || op1_radr == '0) && (op2_ren || op2_radr == '0) &&
                       (unit_en || (unit_row == '0 && unit_opcode == '0)) &&
                       (out_wen || (out_wadr == '0 && out_wdata == '0));
            check("idle_fields_zero", quiet_ok, 1);
            if (cmd_q.size() == 0) begin
                if (out_wen) spur_wen++;
                if (done)    spur_done++;
            end else begin
                c = cmd_q[0];
                if (op1_ren) begin
                    if (n_ren == 0) start_c = cyc;
                    check("op1_radr", op1_radr, (c.b1 + n_ren) % AMOD);
                    check("op2_radr", op2_radr, (c.b2 + n_ren) % AMOD);
                    n_ren++;
                end
                if (unit_en) begin
                    check("unit_row", unit_row, n_unit);
                    check("unit_opcode", unit_opcode, c.op);
                    n_unit++;
                end
                if (out_wen) begin
                    if (c.op == OP_ADD) begin
                        exp_a = (c.bo + n_wr) % AMOD;
                        exp_d = (int'(mem1[(c.b1 + n_wr) % AMOD]) +
                                 int'(mem2[(c.b2 + n_wr) % AMOD])) % DMOD;
                    end else if (c.op == OP_MULT) begin
                        exp_a = (c.bo + n_wr) % AMOD;
                        exp_d = unit_fn(n_wr);
                    end else begin
                        exp_a = c.bo;
                        exp_d = unit_fn(DIMENSION);
                    end
                    check("out_wadr", out_wadr, exp_a);
                    check("out_wdata", out_wdata, exp_d);
                    n_wr++;
                end
                if (done) begin
                    if (c.op == OP_ADD)       begin exp_lat = 2 * ROWS + 1; exp_wr = ROWS; end
                    else if (c.op == OP_MULT) begin exp_lat = 3 * ROWS + 1; exp_wr = ROWS; end
                    else                      begin exp_lat = 2 * ROWS + 2; exp_wr = 1;    end
                    check("latency", cyc - start_c + 1, exp_lat);
                    check("write_count", n_wr, exp_wr);
                    check("unit_pulses", n_unit, ROWS);
                    check("read_count", n_ren, ROWS);
                    void'(cmd_q.pop_front());
                    n_ren = 0; n_unit = 0; n_wr = 0;
                    done_total++;
                end
            end
        end
    end

    // ------------------------------------------------ stimulus helpers
    // Called at a negedge; returns at a negedge with cmd_valid low.
    task automatic push(input logic [1:0] op, input int b1, input int b2, input int bo);
        int   n = 0;
        cmd_t c;
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_op1_base = AW'(b1);
        cmd_op2_base = AW'(b2);
        cmd_out_base = AW'(bo);
        while (!cmd_ready && n < 400) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("push_timeout", (n < 400), 1);
        if (n < 400) begin
            @(posedge wb_clk_i);
            c.op = op; c.b1 = b1; c.b2 = b2; c.bo = bo;
            cmd_q.push_back(c);
        end
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge wb_clk_i);
        while ((busy || cmd_count != 0) && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("idle_timeout", busy, 0);
        check("all_cmds_done", cmd_q.size(), 0);
    endtask

    // ------------------------------------------------ directed sequence
    initial begin
        int n;
        int d0;
        wb_rst_i     = 1'b1;
        cmd_valid    = 1'b0;
        cmd_opcode   = '0;
        cmd_op1_base = '0;
        cmd_op2_base = '0;
        cmd_out_base = '0;
        for (int i = 0; i < AMOD; i++) begin
            mem1[i] = CW'($urandom_range(0, DMOD - 1));
            mem2[i] = CW'($urandom_range(0, DMOD - 1));
        end

        #1;
        check("rst_out_wen", out_wen, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_count", cmd_count, 0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_cmd_count", cmd_count, 0);
        check("post_rst_busy", busy, 0);
        @(negedge wb_clk_i);

        // ADD: 1000 + 30 wraps to 6 in every row.
        for (int r = 0; r < ROWS; r++) begin
            mem1[r]       = CW'(1000);
            mem2[100 + r] = CW'(30);
        end
        d0 = done_total;
        push(OP_ADD, 0, 100, 200);
        check("busy_during_add", busy, 1);
        wait_idle();
        check("add_done_once", done_total - d0, 1);

        // ENCRYPT with a constant unit result.
        uk_mul = 0; uk_add = 123;
        push(OP_ENC, 40, 300, 500);
        wait_idle();

        // MULT with unit_result = row + 7.
        uk_mul = 1; uk_add = 7;
        push(OP_MULT, 10, 20, 700);
        wait_idle();

        // Operand address wrap past the top of the SRAM.
        push(OP_ADD, 1020, 1019, 1015);
        wait_idle();

        uk_mul = 3; uk_add = 11;
        push(OP_DEC, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
             $urandom_range(0, AMOD - 1));
        wait_idle();

        // Back-to-back pushes while the first command runs.
        d0 = done_total;
        push(OP_ADD, 5, 6, 7);
        for (int k = 0; k < 4; k++) begin
            push(logic'(k[0]) ? OP_MULT : OP_ADD, 100 * k, 50 * k, 900 + k);
        end
        check("full_cmd_count", cmd_count, DEPTH);
        check("full_cmd_ready", cmd_ready, 0);
        push(OP_ENC, 333, 444, 555);
        wait_idle();
        check("b2b_done_count", done_total - d0, 6);

        // Randomized batch.
        uk_mul = $urandom_range(0, 20);
        uk_add = $urandom_range(0, DMOD - 1);
        d0 = done_total;
        for (int k = 0; k < 8; k++) begin
            push(2'($urandom_range(0, 3)), $urandom_range(0, AMOD - 1),
                 $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1));
        end
        wait_idle();
        check("rand_done_count", done_total - d0, 8);

        // Reset in the middle of a MULT with two commands queued.
        uk_mul = 1; uk_add = 7;
        push(OP_MULT, 60, 70, 80);
        push(OP_ADD, 1, 2, 3);
        push(OP_ENC, 4, 5, 6);
        check("queued_before_rst", cmd_count, 2);
        n = 0;
        while (!(unit_en && unit_row == 4'd5) && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("row5_timeout", (n < 300), 1);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        check("mid_rst_out_wen", out_wen, 0);
        check("mid_rst_out_wdata", out_wdata, 0);
        check("mid_rst_unit_en", unit_en, 0);
        check("mid_rst_op1_ren", op1_ren, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cmd_count", cmd_count, 0);
        check("mid_rst_busy", busy, 0);
        d0 = done_total;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("rel_cmd_ready", cmd_ready, 1);
        repeat (60) @(negedge wb_clk_i);
        check("rel_busy", busy, 0);
        check("rel_cmd_count", cmd_count, 0);
        check("no_done_after_rst", done_total - d0, 0);
        check("spurious_wen", spur_wen, 0);
        check("spurious_done", spur_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fhe_op_sequencer.md
FHE_OP_SEQUENCER -- requirements
Module: fhe_op_sequencer

Interface
REQ-001 SHALL have parameter CIPHERTEXT_WIDTH, default 10, ciphertext entry width.
REQ-002 SHALL have parameter DIMENSION, default 10, last row index; an operation covers rows 0..DIMENSION.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, SRAM address width.
REQ-004 SHALL have parameter DIM_WIDTH, default 4, row counter width.
REQ-005 SHALL have parameter CMD_DEPTH, default 4, command queue depth, power of two.
REQ-006 SHALL have ports: wb_clk_i in 1, sole clock; wb_rst_i in 1, asynchronous active-high reset.
REQ-007 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_opcode in 2 (00 encrypt, 01 decrypt, 10 add, 11 mult); cmd_op1_base, cmd_op2_base, cmd_out_base in ADDR_WIDTH each.
REQ-008 SHALL have SRAM read ports: op1_ren, op2_ren out 1; op1_radr, op2_radr out ADDR_WIDTH; op1_rdata, op2_rdata in CIPHERTEXT_WIDTH.
REQ-009 SHALL have compute-unit ports: unit_en out 1; unit_opcode out 2; unit_row out DIM_WIDTH; unit_result in CIPHERTEXT_WIDTH.
REQ-010 SHALL have result ports: out_wen out 1; out_wadr out ADDR_WIDTH; out_wdata out CIPHERTEXT_WIDTH.
REQ-011 SHALL have status ports: busy out 1; done out 1; cmd_count out log2(CMD_DEPTH)+1.

Function
REQ-012 Queue: FIFO of CMD_DEPTH entries; cmd_ready = (cmd_count < CMD_DEPTH), computed from registered count only; push on cmd_valid & cmd_ready.
REQ-013 A push and a pop in the same cycle SHALL leave cmd_count unchanged; when full, cmd_ready stays 0 even if a pop occurs that cycle.
REQ-014 FSM states IDLE, READ, EXEC, WRITE, FINISH.
REQ-015 IDLE: if queue non-empty, pop head into working registers, row=0, go READ; busy=0 only in IDLE with empty queue.
REQ-016 READ (1 cycle): op1_ren=op2_ren=1, op1_radr=op1_base+row, op2_radr=op2_base+row, both modulo 2^ADDR_WIDTH; go EXEC.
REQ-017 EXEC (1 cycle): rdata valid; unit_en=1, unit_row=row, unit_opcode=working opcode.
REQ-018 ADD in EXEC: out_wen=1, out_wadr=out_base+row (wrapping), out_wdata=(op1_rdata+op2_rdata) mod 2^CIPHERTEXT_WIDTH.
REQ-019 MULT: EXEC goes WRITE; WRITE writes unit_result to out_base+row.
REQ-020 ENCRYPT/DECRYPT: no per-row write; after EXEC of row DIMENSION go WRITE once, writing unit_result to out_base.
REQ-021 After a row's final action: if row<DIMENSION, row+1 and go READ; else go FINISH.
REQ-022 FINISH: done=1 for exactly one cycle, go IDLE; next queued command leaves IDLE the following cycle.
REQ-023 Latency from pop to done (D=DIMENSION+1 rows): ADD 2D+1, MULT 3D+1, ENC/DEC 2D+2 cycles.
REQ-024 All strobes (ren, unit_en, out_wen, done) SHALL be 0 outside the states named; addresses/data SHALL be 0 when the strobe is 0.
REQ-025 Commands pushed while busy SHALL NOT alter the working registers of the active operation.

Reset
REQ-026 wb_rst_i asserted SHALL immediately force IDLE, clear queue (cmd_count=0), row=0, all outputs 0, cmd_ready=1 after release.
REQ-027 Reset mid-operation SHALL abort with no further out_wen or done; queued commands are discarded.

Verification
REQ-028 ADD, op1 rows=1000, op2 rows=30, bases 0/100/200 -> 11 writes, addr 200..210, data 6 each, done at cycle 23 after pop.
REQ-029 ENCRYPT, unit_result=123 -> 11 unit_en pulses, rows 0..10, single write addr out_base data 123, no other out_wen.
REQ-030 Push 5 commands back-to-back while first runs -> cmd_ready=0 on 5th once count=4, 5th accepted after pop; all 5 complete in order.
REQ-031 op1_base=1020 -> op1_radr 1020,1021,1022,1023,0..6.
REQ-032 Assert wb_rst_i at row 5 of MULT with 2 queued -> all outputs 0 same cycle, cmd_count=0, no done.
REQ-033 MULT, unit_result=row+7 -> writes at out_base+r with data r+7, three cycles per row, done once.
